// File: rtl/io_bus_master_pkg.sv
// Shared definitions for the I/O bus master: op codes, FSM state encodings, register map.
package io_bus_master_pkg;

   localparam logic [1:0] IO_OP_READ  = 2'd0;
   localparam logic [1:0] IO_OP_WRITE = 2'd1;
   localparam logic [1:0] IO_OP_SET   = 2'd2;
   localparam logic [1:0] IO_OP_CLR   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR      = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   // Register map of the GPIO register file; PINx read back the pins and ignore writes.
   localparam logic [5:0] PINB  = 6'h16;
   localparam logic [5:0] DDRB  = 6'h17;
   localparam logic [5:0] PORTB = 6'h18;
   localparam logic [5:0] PINA  = 6'h19;
   localparam logic [5:0] DDRA  = 6'h1A;
   localparam logic [5:0] PORTA = 6'h1B;

endpackage

// File: rtl/io_bit_modify.sv
// Single-bit set/clear of a register value; combinational, no backpressure.
// Only compiled when IO_MASTER_RMW_EN is defined.
`ifdef IO_MASTER_RMW_EN
module io_bit_modify #(
   parameter int DATA_WIDTH    = 8,
   parameter int BIT_IDX_WIDTH = 3
) (
   input  logic [DATA_WIDTH-1:0]    value,
   input  logic [BIT_IDX_WIDTH-1:0] bit_idx,
   input  logic                     set,
   output logic [DATA_WIDTH-1:0]    result
);

   logic [DATA_WIDTH-1:0] mask;

   assign mask   = DATA_WIDTH'(1) << bit_idx;
   assign result = set ? (value | mask) : (value & ~mask);

endmodule
`endif

// File: rtl/io_bus_master.sv
// Sequences READ/WRITE/SET_BIT/CLR_BIT onto the cs/oe/we I/O bus; response 3/2/4 cycles after accept, no response backpressure.
// IO_MASTER_RMW_EN compiles the read-modify-write path; without it SET/CLR answer with an error and no bus cycle.
module io_bus_master
   import io_bus_master_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 6,
   parameter int BIT_IDX_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [BIT_IDX_WIDTH-1:0] req_bit,
   output logic                     rsp_valid,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     rsp_err,
   output logic                     cs,
   output logic                     oe,
   output logic                     we,
   output logic [ADDR_WIDTH-1:0]    address,
   inout  wire  [DATA_WIDTH-1:0]    data
);

   state_t                  state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    cs_q, cs_d;
   logic                    oe_q, oe_d;
   logic                    we_q, we_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0]   wr_val;
   logic                    ro_addr;

`ifdef IO_MASTER_RMW_EN
   localparam bit RMW_EN = 1'b1;

   logic [BIT_IDX_WIDTH-1:0] bit_q, bit_d;
   logic [DATA_WIDTH-1:0]    mod_val;

   // The modified value is formed from the sampled read data during WR.
   io_bit_modify #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BIT_IDX_WIDTH(BIT_IDX_WIDTH)
   ) u_bit_modify (
      .value  (rdata_q),
      .bit_idx(bit_q),
      .set    (op_q == IO_OP_SET),
      .result (mod_val)
   );

   assign wr_val = (op_q == IO_OP_WRITE) ? wdata_q : mod_val;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_q <= '0;
      end else begin
         bit_q <= bit_d;
      end
   end

   always_comb begin
      bit_d = bit_q;
      if (state_q == ST_IDLE && req_valid) begin
         bit_d = req_bit;
      end
   end
`else
   localparam bit RMW_EN = 1'b0;

   logic unused_req_bit;

   assign unused_req_bit = ^req_bit;
   assign wr_val         = wdata_q;
`endif

   assign ro_addr = (addr_q == ADDR_WIDTH'(PINA)) || (addr_q == ADDR_WIDTH'(PINB));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cs_d        = cs_q;
      oe_d        = oe_q;
      we_d        = we_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_op == IO_OP_WRITE) begin
                  state_d = ST_WR;
                  cs_d    = 1'b1;
                  we_d    = 1'b1;
               end else if (req_op == IO_OP_READ || RMW_EN) begin
                  state_d = ST_RD_ADDR;
                  cs_d    = 1'b1;
               end else begin
                  // Bit ops without the RMW path: immediate error, bus untouched.
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end

         ST_RD_ADDR: begin
            state_d = ST_RD_DATA;
            oe_d    = 1'b1;
         end

         ST_RD_DATA: begin
            rdata_d = data;
            oe_d    = 1'b0;
            if (op_q == IO_OP_READ) begin
               state_d     = ST_RESP;
               cs_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = data;
            end else begin
               state_d = ST_WR;
               we_d    = 1'b1;
            end
         end

         ST_WR: begin
            state_d     = ST_RESP;
            cs_d        = 1'b0;
            we_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (op_q == IO_OP_WRITE) ? '0 : rdata_q;
            rsp_err_d   = ro_addr;
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cs_d    = 1'b0;
            oe_d    = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         cs_q        <= 1'b0;
         oe_q        <= 1'b0;
         we_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         cs_q        <= cs_d;
         oe_q        <= oe_d;
         we_q        <= we_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign cs        = cs_q;
   assign oe        = oe_q;
   assign we        = we_q;
   assign address   = addr_q;

   // Only the WR cycle drives the bus, so it can never overlap the slave's oe window.
   assign data = we_q ? wr_val : {DATA_WIDTH{1'bz}};

endmodule
